// File: rtl/glitch_filter_pkg.sv
// Shared definitions for the glitch filter: FSM state encoding and a
// constant-width helper for sizing the stability counter.
package glitch_filter_pkg;

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_QUAL_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_QUAL_LOW  = 2'd3;

  typedef enum logic [1:0] {
    LOW       = ST_LOW,
    QUAL_HIGH = ST_QUAL_HIGH,
    HIGH      = ST_HIGH,
    QUAL_LOW  = ST_QUAL_LOW
  } state_t;

  // Smallest n with 2**n >= value; only ever evaluated on constants.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/glitch_filter_sync.sv
// Plain flip-flop synchronizer chain for an asynchronous single-bit level.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// Synchronizes an asynchronous gate output and only passes level changes
// that stay stable for STABLE_CYCLES clocks; shorter pulses are counted.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din,
  input  logic             enable,
  input  logic             clr_glitch,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             glitch_sat,
  output logic [1:0]       state
);

  localparam int             CW      = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST    = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  ONE     = CW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic          s;
  state_t        st;
  logic [CW-1:0] stable_cnt;
  logic          reject;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (din),
    .q       (s)
  );

  // A qualification is rejected when the sample falls back to the old level.
  assign reject = enable && (((st == QUAL_HIGH) && !s) || ((st == QUAL_LOW) && s));
  assign state  = st;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st         <= LOW;
      stable_cnt <= '0;
      dout       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (enable) begin
        case (st)
          LOW: begin
            if (s) begin
              if (STABLE_CYCLES == 1) begin
                st   <= HIGH;
                dout <= 1'b1;
                rise <= 1'b1;
              end else begin
                st         <= QUAL_HIGH;
                stable_cnt <= ONE;
              end
            end
          end
          QUAL_HIGH: begin
            if (!s) begin
              st <= LOW;
            end else if (stable_cnt == LAST) begin
              st   <= HIGH;
              dout <= 1'b1;
              rise <= 1'b1;
            end else begin
              stable_cnt <= stable_cnt + ONE;
            end
          end
          HIGH: begin
            if (!s) begin
              if (STABLE_CYCLES == 1) begin
                st   <= LOW;
                dout <= 1'b0;
                fall <= 1'b1;
              end else begin
                st         <= QUAL_LOW;
                stable_cnt <= ONE;
              end
            end
          end
          QUAL_LOW: begin
            if (s) begin
              st <= HIGH;
            end else if (stable_cnt == LAST) begin
              st   <= LOW;
              dout <= 1'b0;
              fall <= 1'b1;
            end else begin
              stable_cnt <= stable_cnt + ONE;
            end
          end
          default: st <= LOW;
        endcase
      end
    end
  end

  // Clear has priority over a rejection landing in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt <= '0;
      glitch_sat <= 1'b0;
    end else if (clr_glitch) begin
      glitch_cnt <= '0;
      glitch_sat <= 1'b0;
    end else if (reject && (glitch_cnt != CNT_MAX)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
      if (glitch_cnt == CNT_MAX - 1'b1) glitch_sat <= 1'b1;
    end
  end

endmodule
